// File: rtl/registro_entrada_pkg.sv
// Shared constants for the entry path: game-state encodings, field width and value limits.
// The controller and the entry-clear generator decode estadoJogo with the same constants.
package registro_entrada_pkg;

    localparam int unsigned FIELD_W     = 4;
    localparam int unsigned VAL_MIN_DEF = 1;
    localparam int unsigned VAL_MAX_DEF = 9;

    localparam logic [2:0] recebeLinha  = 3'b000;
    localparam logic [2:0] recebeColuna = 3'b001;
    localparam logic [2:0] verificaPos  = 3'b010;
    localparam logic [2:0] recebeValor  = 3'b011;
    localparam logic [2:0] verificaJogo = 3'b100;
    localparam logic [2:0] fimJogo      = 3'b101;

    function automatic logic in_range(input logic [FIELD_W-1:0] v,
                                      input logic [FIELD_W-1:0] lo,
                                      input logic [FIELD_W-1:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/debounce_botao.sv
// Synchronizes and debounces an active-low pushbutton; emits a one-cycle registered pulse
// when the debounced level falls (press). Releases produce no pulse.
module debounce_botao #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n_i,
    output logic pressiona_o
);

    localparam int unsigned     CntW    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic            key_s1_q, key_s2_q;
    logic            stable_q, stable_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      vld_q, vld_d;
    logic            armed_q, armed_d;
    logic            press_q, press_d;

    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        press_d  = 1'b0;
        vld_d    = {vld_q[0], 1'b1};
        // A key already held when reset releases must be seen released before it can press.
        armed_d  = armed_q | (vld_q[1] & key_s2_q & stable_q);
        if (key_s2_q != stable_q) begin
            if (cnt_q == CntLast) begin
                stable_d = key_s2_q;
                press_d  = stable_q & armed_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            key_s1_q <= 1'b1;
            key_s2_q <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
            vld_q    <= '0;
            armed_q  <= 1'b0;
            press_q  <= 1'b0;
        end else begin
            key_s1_q <= key_n_i;
            key_s2_q <= key_s1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            vld_q    <= vld_d;
            armed_q  <= armed_d;
            press_q  <= press_d;
        end
    end

    assign pressiona_o = press_q;

endmodule

// File: rtl/registro_entrada.sv
// Captures row, column and value from the switches, one field per confirmed key press,
// steered by the game state; pulses confirma on accepted entries and erro on out-of-range ones.
module registro_entrada
    import registro_entrada_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned VAL_MIN         = VAL_MIN_DEF,
    parameter int unsigned VAL_MAX         = VAL_MAX_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               keyConfirma,
    input  logic [FIELD_W-1:0] switches,
    input  logic [2:0]         estadoJogo,
    input  logic               limpaEntrada,
    output logic [FIELD_W-1:0] linha,
    output logic [FIELD_W-1:0] coluna,
    output logic [FIELD_W-1:0] valor,
    output logic               linhaValida,
    output logic               colunaValida,
    output logic               valorValido,
    output logic               confirma,
    output logic               erro
);

    localparam logic [FIELD_W-1:0] MinF = FIELD_W'(VAL_MIN);
    localparam logic [FIELD_W-1:0] MaxF = FIELD_W'(VAL_MAX);

    logic               pressiona;
    logic [FIELD_W-1:0] sw_s1_q, sw_s2_q;
    logic [FIELD_W-1:0] linha_q, linha_d, coluna_q, coluna_d, valor_q, valor_d;
    logic               lv_q, lv_d, cv_q, cv_d, vv_q, vv_d;
    logic               confirma_q, confirma_d, erro_q, erro_d;
    logic               ok;

    debounce_botao #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk        (clk),
        .reset      (reset),
        .key_n_i    (keyConfirma),
        .pressiona_o(pressiona)
    );

    assign ok = in_range(sw_s2_q, MinF, MaxF);

    always_comb begin
        linha_d    = linha_q;
        coluna_d   = coluna_q;
        valor_d    = valor_q;
        lv_d       = lv_q;
        cv_d       = cv_q;
        vv_d       = vv_q;
        confirma_d = 1'b0;
        erro_d     = 1'b0;
        // Clear wins over a simultaneous press; that press is dropped.
        if (limpaEntrada) begin
            linha_d  = '0;
            coluna_d = '0;
            valor_d  = '0;
            lv_d     = 1'b0;
            cv_d     = 1'b0;
            vv_d     = 1'b0;
        end else if (pressiona) begin
            case (estadoJogo)
                recebeLinha: begin
                    if (ok) begin
                        linha_d = sw_s2_q;
                        lv_d    = 1'b1;
                    end
                    confirma_d = ok;
                    erro_d     = !ok;
                end
                recebeColuna: begin
                    if (ok) begin
                        coluna_d = sw_s2_q;
                        cv_d     = 1'b1;
                    end
                    confirma_d = ok;
                    erro_d     = !ok;
                end
                recebeValor: begin
                    if (ok) begin
                        valor_d = sw_s2_q;
                        vv_d    = 1'b1;
                    end
                    confirma_d = ok;
                    erro_d     = !ok;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sw_s1_q    <= '0;
            sw_s2_q    <= '0;
            linha_q    <= '0;
            coluna_q   <= '0;
            valor_q    <= '0;
            lv_q       <= 1'b0;
            cv_q       <= 1'b0;
            vv_q       <= 1'b0;
            confirma_q <= 1'b0;
            erro_q     <= 1'b0;
        end else begin
            sw_s1_q    <= switches;
            sw_s2_q    <= sw_s1_q;
            linha_q    <= linha_d;
            coluna_q   <= coluna_d;
            valor_q    <= valor_d;
            lv_q       <= lv_d;
            cv_q       <= cv_d;
            vv_q       <= vv_d;
            confirma_q <= confirma_d;
            erro_q     <= erro_d;
        end
    end

    assign linha        = linha_q;
    assign coluna       = coluna_q;
    assign valor        = valor_q;
    assign linhaValida  = lv_q;
    assign colunaValida = cv_q;
    assign valorValido  = vv_q;
    assign confirma     = confirma_q;
    assign erro         = erro_q;

endmodule

// File: tb/tb_registro_entrada.sv
// Directed bench for registro_entrada with a short debounce window of 4 cycles.
module tb_registro_entrada;
    import registro_entrada_pkg::*;

    logic       clk;
    logic       reset;
    logic       keyConfirma;
    logic [3:0] switches;
    logic [2:0] estadoJogo;
    logic       limpaEntrada;
    logic [3:0] linha, coluna, valor;
    logic       linhaValida, colunaValida, valorValido;
    logic       confirma, erro;

    int vectors     = 0;
    int miscompares = 0;
    int conf_cnt    = 0;
    int err_cnt     = 0;
    int both_cnt    = 0;
    int wide_cnt    = 0;
    logic conf_prev = 1'b0;
    logic err_prev  = 1'b0;
    int base_c, base_e;

    registro_entrada #(
        .DEBOUNCE_CYCLES(4),
        .VAL_MIN        (1),
        .VAL_MAX        (9)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .keyConfirma (keyConfirma),
        .switches    (switches),
        .estadoJogo  (estadoJogo),
        .limpaEntrada(limpaEntrada),
        .linha       (linha),
        .coluna      (coluna),
        .valor       (valor),
        .linhaValida (linhaValida),
        .colunaValida(colunaValida),
        .valorValido (valorValido),
        .confirma    (confirma),
        .erro        (erro)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor: counts pulses, overlaps and pulses wider than one cycle.
    always @(negedge clk) begin
        if (confirma) conf_cnt <= conf_cnt + 1;
        if (erro) err_cnt <= err_cnt + 1;
        if (confirma && erro) both_cnt <= both_cnt + 1;
        if ((confirma && conf_prev) || (erro && err_prev)) wide_cnt <= wide_cnt + 1;
        conf_prev <= confirma;
        err_prev  <= erro;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic press_release;
        keyConfirma = 1'b0;
        repeat (10) tick();
        keyConfirma = 1'b1;
        repeat (10) tick();
    endtask

    initial begin
        reset        = 1'b1;
        keyConfirma  = 1'b1;
        switches     = 4'd0;
        estadoJogo   = recebeLinha;
        limpaEntrada = 1'b0;
        repeat (3) tick();
        chk("reset_fields", int'({linha, coluna, valor}), 0);
        chk("reset_flags", int'({linhaValida, colunaValida, valorValido, confirma, erro}), 0);
        reset = 1'b0;
        repeat (5) tick();

        // Row capture with exact latency.
        switches = 4'd5;
        base_c   = conf_cnt;
        keyConfirma = 1'b0;
        repeat (6) tick();
        chk("row_no_early", int'(confirma), 0);
        tick();
        chk("row_confirma_t7", int'(confirma), 1);
        chk("row_linha", int'(linha), 5);
        chk("row_valid", int'(linhaValida), 1);
        tick();
        chk("row_pulse_width", int'(confirma), 0);
        repeat (2) tick();
        keyConfirma = 1'b1;
        repeat (10) tick();
        chk("row_one_pulse", conf_cnt - base_c, 1);

        // Bounce rejection.
        switches = 4'd7;
        base_c   = conf_cnt;
        base_e   = err_cnt;
        repeat (3) begin
            keyConfirma = 1'b0;
            repeat (2) tick();
            keyConfirma = 1'b1;
            repeat (2) tick();
        end
        repeat (4) tick();
        chk("bounce_no_pulse", (conf_cnt - base_c) + (err_cnt - base_e), 0);
        press_release();
        chk("bounce_one_confirma", conf_cnt - base_c, 1);
        chk("bounce_linha", int'(linha), 7);

        // Range check on value field.
        estadoJogo = recebeValor;
        switches   = 4'd0;
        base_c     = conf_cnt;
        base_e     = err_cnt;
        press_release();
        chk("range_zero_erro", err_cnt - base_e, 1);
        chk("range_zero_noconf", conf_cnt - base_c, 0);
        chk("range_zero_invalid", int'(valorValido), 0);
        switches = 4'd10;
        press_release();
        chk("range_ten_erro", err_cnt - base_e, 2);
        chk("range_ten_invalid", int'({valorValido, valor}), 0);
        switches = 4'd9;
        press_release();
        chk("range_nine_conf", conf_cnt - base_c, 1);
        chk("range_nine_valor", int'({valorValido, valor}), 16 + 9);

        // Column capture.
        estadoJogo = recebeColuna;
        switches   = 4'd2;
        press_release();
        chk("col_capture", int'({colunaValida, coluna}), 16 + 2);

        // Ignored state.
        estadoJogo = verificaPos;
        switches   = 4'd3;
        base_c     = conf_cnt;
        base_e     = err_cnt;
        press_release();
        chk("ignored_no_pulse", (conf_cnt - base_c) + (err_cnt - base_e), 0);
        chk("ignored_fields", int'({linha, coluna, valor}), 'h729);
        chk("ignored_flags", int'({linhaValida, colunaValida, valorValido}), 7);

        // Clear in the press-event cycle.
        estadoJogo = recebeColuna;
        switches   = 4'd4;
        base_c     = conf_cnt;
        base_e     = err_cnt;
        keyConfirma = 1'b0;
        repeat (6) tick();
        limpaEntrada = 1'b1;
        tick();
        limpaEntrada = 1'b0;
        chk("clear_fields", int'({linha, coluna, valor}), 0);
        chk("clear_flags", int'({linhaValida, colunaValida, valorValido, confirma, erro}), 0);
        repeat (10) tick();
        chk("clear_held_no_pulse", (conf_cnt - base_c) + (err_cnt - base_e), 0);
        keyConfirma = 1'b1;
        repeat (10) tick();
        press_release();
        chk("clear_recapture", int'({colunaValida, coluna}), 16 + 4);
        chk("clear_recapture_conf", conf_cnt - base_c, 1);

        // Reset during the debounce window of a held key.
        estadoJogo = recebeLinha;
        switches   = 4'd6;
        keyConfirma = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        repeat (2) tick();
        reset  = 1'b0;
        base_c = conf_cnt;
        base_e = err_cnt;
        repeat (20) tick();
        chk("rst_held_no_pulse", (conf_cnt - base_c) + (err_cnt - base_e), 0);
        chk("rst_fields", int'({linha, coluna, valor, linhaValida, colunaValida, valorValido}), 0);
        keyConfirma = 1'b1;
        repeat (10) tick();
        press_release();
        chk("rst_new_press_conf", conf_cnt - base_c, 1);
        chk("rst_new_press_linha", int'({linhaValida, linha}), 16 + 6);

        chk("pulse_exclusive", both_cnt, 0);
        chk("pulse_single_cycle", wide_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
